// File: rtl/instr_fetch_pkg.sv
// Shared ISA definitions and fetch-stage types for the instruction fetch slice.
// Opcode values must match the instruction memory image and the control unit.
package instr_fetch_pkg;

  localparam int OP_LDACI     = 0;
  localparam int OP_MVAC      = 4;
  localparam int OP_STACI     = 13;
  localparam int OP_JPNZ      = 27;
  localparam int OP_ENDOP     = 28;
  localparam int OP_NOP       = 34;
  localparam int NUM_OPCODES  = 35;
  localparam int HALT_OPCODE  = OP_ENDOP;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH_OP  = 3'd1,
    ST_LATCH_OP  = 3'd2,
    ST_LATCH_ARG = 3'd3,
    ST_ISSUE     = 3'd4,
    ST_HALT      = 3'd5
  } fetch_state_t;

  // Only the immediate-carrying opcodes occupy two bytes.
  function automatic logic is_two_byte(input int unsigned op);
    return (op == OP_LDACI) || (op == OP_STACI) || (op == OP_JPNZ);
  endfunction

endpackage

// File: rtl/instr_len_dec.sv
// Combinational length/legality decode of a raw opcode byte.
// Opcodes outside the ISA are reported illegal and treated as one byte long.
module instr_len_dec
  import instr_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_opcode,
  output logic                  o_has_operand,
  output logic                  o_illegal_op
);

  logic w_illegal;

  assign w_illegal     = (i_opcode > DATA_WIDTH'(NUM_OPCODES - 1));
  assign o_illegal_op  = w_illegal;
  assign o_has_operand = !w_illegal &&
                         ((i_opcode == DATA_WIDTH'(OP_LDACI)) ||
                          (i_opcode == DATA_WIDTH'(OP_STACI)) ||
                          (i_opcode == DATA_WIDTH'(OP_JPNZ)));

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: drives instruction memory, assembles opcode + optional operand,
// and hands complete instructions to the control unit over valid/ready.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int HALT_OPCODE = 28
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] r_addr,
  input  logic [DATA_WIDTH-1:0] r_instr,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] opcode,
  output logic [DATA_WIDTH-1:0] operand,
  output logic                  has_operand,
  output logic                  illegal_op,
  output logic [ADDR_WIDTH-1:0] pc,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic                  halted
);

  fetch_state_t          r_state;
  fetch_state_t          w_state_next;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_pc_next;
  logic [DATA_WIDTH-1:0] r_opcode;
  logic [DATA_WIDTH-1:0] r_operand;
  logic                  r_has_operand;
  logic                  r_illegal_op;
  logic                  r_halted;
  logic                  w_accept;
  logic                  w_is_halt;
  logic                  w_dec_has_operand;
  logic                  w_dec_illegal;

  // Decode the byte arriving from memory so length is known in LATCH_OP.
  instr_len_dec #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_len_dec (
    .i_opcode      (r_instr),
    .o_has_operand (w_dec_has_operand),
    .o_illegal_op  (w_dec_illegal)
  );

  assign w_accept  = (r_state == ST_ISSUE) && instr_ready;
  assign w_is_halt = (r_opcode == DATA_WIDTH'(HALT_OPCODE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_next = ST_FETCH_OP;
      end
      ST_FETCH_OP: begin
        w_state_next = ST_LATCH_OP;
      end
      ST_LATCH_OP: begin
        w_state_next = w_dec_has_operand ? ST_LATCH_ARG : ST_ISSUE;
      end
      ST_LATCH_ARG: begin
        w_state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (w_accept) w_state_next = w_is_halt ? ST_HALT : ST_FETCH_OP;
      end
      ST_HALT: begin
        if (start) w_state_next = ST_FETCH_OP;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= '0;
      r_pc_next     <= '0;
      r_opcode      <= '0;
      r_operand     <= '0;
      r_has_operand <= 1'b0;
      r_illegal_op  <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) r_pc <= '0;
        end
        ST_LATCH_OP: begin
          r_opcode      <= r_instr;
          r_has_operand <= w_dec_has_operand;
          r_illegal_op  <= w_dec_illegal;
          if (!w_dec_has_operand) begin
            r_operand <= '0;
            r_pc_next <= r_pc + ADDR_WIDTH'(1);
          end
        end
        ST_LATCH_ARG: begin
          r_operand <= r_instr;
          r_pc_next <= r_pc + ADDR_WIDTH'(2);
        end
        ST_ISSUE: begin
          // Halt wins over redirect; pc stays on the ENDOP byte.
          if (w_accept) begin
            if (w_is_halt) begin
              r_halted <= 1'b1;
            end else if (redirect) begin
              r_pc <= redirect_addr;
            end else begin
              r_pc <= r_pc_next;
            end
          end
        end
        ST_HALT: begin
          if (start) begin
            r_pc     <= '0;
            r_halted <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Operand byte is requested while the opcode is being latched; wraps naturally.
  assign r_addr      = (r_state == ST_LATCH_OP) ? (r_pc + ADDR_WIDTH'(1)) : r_pc;
  assign instr_valid = (r_state == ST_ISSUE);
  assign opcode      = r_opcode;
  assign operand     = r_operand;
  assign has_operand = r_has_operand;
  assign illegal_op  = r_illegal_op;
  assign pc          = r_pc;
  assign halted      = r_halted;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch paired with a registered-read instruction memory.
module tb_instr_fetch;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       instr_ready = 1'b0;
  logic       redirect = 1'b0;
  logic [7:0] redirect_addr = 8'd0;
  logic [7:0] r_addr;
  logic [7:0] r_instr;
  logic       instr_valid;
  logic [7:0] opcode;
  logic [7:0] operand;
  logic       has_operand;
  logic       illegal_op;
  logic [7:0] pc;
  logic       halted;

  logic [7:0] mem [256];

  int checks = 0;
  int errors = 0;

  instr_fetch #(
    .DATA_WIDTH  (8),
    .ADDR_WIDTH  (8),
    .HALT_OPCODE (28)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .r_addr        (r_addr),
    .r_instr       (r_instr),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .opcode        (opcode),
    .operand       (operand),
    .has_operand   (has_operand),
    .illegal_op    (illegal_op),
    .pc            (pc),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) r_instr <= mem[r_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'd4;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    instr_ready = 1'b0;
    redirect = 1'b0;
    redirect_addr = 8'd0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_valid(input int max_cyc, output int n, output bit ok);
    n = 0;
    while (n < max_cyc && !instr_valid) begin
      step();
      n++;
    end
    ok = instr_valid;
  endtask

  task automatic accept(input bit rd, input logic [7:0] ra);
    instr_ready = 1'b1;
    redirect = rd;
    redirect_addr = ra;
    step();
    instr_ready = 1'b0;
    redirect = 1'b0;
    redirect_addr = 8'd0;
  endtask

  task automatic test_reset();
    clear_mem();
    rst_n = 1'b0;
    #2;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", instr_valid); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %0b want 0", halted); end
    checks++; if ({pc, r_addr} !== 16'h0) begin errors++; $display("FAIL reset_addr: pc %0d r_addr %0d want 0 0", pc, r_addr); end
    checks++; if ({opcode, operand, has_operand, illegal_op} !== 18'h0) begin errors++; $display("FAIL reset_regs: op %0d arg %0d has %0b ill %0b want all 0", opcode, operand, has_operand, illegal_op); end
    step();
    step();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL idle_no_start: valid %0b want 0", instr_valid); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    clear_mem();
    mem[0] = 8'd0; mem[1] = 8'd0; mem[2] = 8'd4;
    do_reset();
    instr_ready = 1'b1;
    pulse_start();
    step();
    step();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL basic_early: valid %0b at T3 want 0", instr_valid); end
    step();
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL basic_t4_valid: got %0b want 1", instr_valid); end
    checks++; if ({opcode, operand, has_operand, pc} !== {8'd0, 8'd0, 1'b1, 8'd0}) begin errors++; $display("FAIL basic_t4_fields: op %0d arg %0d has %0b pc %0d want 0 0 1 0", opcode, operand, has_operand, pc); end
    step();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL basic_after_accept: valid %0b want 0", instr_valid); end
    step();
    step();
    instr_ready = 1'b0;
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL basic_t7_valid: got %0b want 1", instr_valid); end
    checks++; if ({opcode, operand, has_operand, pc} !== {8'd4, 8'd0, 1'b0, 8'd2}) begin errors++; $display("FAIL basic_t7_fields: op %0d arg %0d has %0b pc %0d want 4 0 0 2", opcode, operand, has_operand, pc); end
  endtask

  task automatic test_backpressure();
    int n;
    bit ok;
    clear_mem();
    mem[0] = 8'd0; mem[1] = 8'h5A; mem[2] = 8'd4;
    do_reset();
    pulse_start();
    wait_valid(10, n, ok);
    checks++; if (!ok || n != 3) begin errors++; $display("FAIL bp_first_latency: valid %0b after %0d cycles want 1 after 3", ok, n); end
    for (int i = 0; i < 5; i++) begin
      start = 1'b1;
      step();
      checks++;
      if ({instr_valid, opcode, operand, pc, r_addr} !== {1'b1, 8'd0, 8'h5A, 8'd0, 8'd0}) begin
        errors++;
        $display("FAIL bp_hold_%0d: valid %0b op %0d arg %0h pc %0d r_addr %0d want 1 0 5a 0 0", i, instr_valid, opcode, operand, pc, r_addr);
      end
    end
    start = 1'b0;
    accept(1'b0, 8'd0);
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL bp_single_accept: valid %0b want 0", instr_valid); end
    wait_valid(10, n, ok);
    checks++; if (!ok || n != 2 || pc !== 8'd2 || opcode !== 8'd4) begin errors++; $display("FAIL bp_next: ok %0b n %0d pc %0d op %0d want 1 2 2 4", ok, n, pc, opcode); end
  endtask

  task automatic test_jump();
    int n;
    bit ok;
    clear_mem();
    mem[0] = 8'd27; mem[1] = 8'd55; mem[55] = 8'd27; mem[56] = 8'd27;
    do_reset();
    pulse_start();
    wait_valid(10, n, ok);
    accept(1'b1, 8'd55);
    wait_valid(10, n, ok);
    checks++; if (!ok || n != 3) begin errors++; $display("FAIL jmp_latency: ok %0b n %0d want 1 3", ok, n); end
    checks++; if ({pc, opcode, operand, has_operand} !== {8'd55, 8'd27, 8'd27, 1'b1}) begin errors++; $display("FAIL jmp_at55: pc %0d op %0d arg %0d has %0b want 55 27 27 1", pc, opcode, operand, has_operand); end
    accept(1'b1, 8'd27);
    wait_valid(10, n, ok);
    checks++; if (!ok || pc !== 8'd27 || opcode !== 8'd4) begin errors++; $display("FAIL jmp_taken: ok %0b pc %0d op %0d want 1 27 4", ok, pc, opcode); end
    do_reset();
    pulse_start();
    wait_valid(10, n, ok);
    accept(1'b1, 8'd55);
    redirect = 1'b1;
    redirect_addr = 8'd200;
    wait_valid(10, n, ok);
    step();
    step();
    accept(1'b0, 8'd0);
    wait_valid(10, n, ok);
    checks++; if (!ok || pc !== 8'd57) begin errors++; $display("FAIL jmp_not_taken: ok %0b pc %0d want 1 57", ok, pc); end
  endtask

  task automatic test_halt();
    int n;
    int seen;
    bit ok;
    clear_mem();
    mem[0] = 8'd27; mem[1] = 8'd92; mem[92] = 8'd28;
    do_reset();
    pulse_start();
    wait_valid(10, n, ok);
    accept(1'b1, 8'd92);
    wait_valid(10, n, ok);
    checks++; if (!ok || pc !== 8'd92 || opcode !== 8'd28) begin errors++; $display("FAIL halt_endop: ok %0b pc %0d op %0d want 1 92 28", ok, pc, opcode); end
    accept(1'b1, 8'd40);
    checks++; if (halted !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("FAIL halt_enter: halted %0b valid %0b want 1 0", halted, instr_valid); end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (instr_valid) seen++;
    end
    checks++; if (seen != 0 || halted !== 1'b1 || r_addr !== 8'd92) begin errors++; $display("FAIL halt_quiet: valids %0d halted %0b r_addr %0d want 0 1 92", seen, halted, r_addr); end
    pulse_start();
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_restart: halted %0b want 0", halted); end
    wait_valid(10, n, ok);
    checks++; if (!ok || n != 3 || pc !== 8'd0 || opcode !== 8'd27) begin errors++; $display("FAIL halt_refetch: ok %0b n %0d pc %0d op %0d want 1 3 0 27", ok, n, pc, opcode); end
  endtask

  task automatic test_wrap();
    int n;
    bit ok;
    clear_mem();
    mem[0] = 8'd5; mem[1] = 8'd4; mem[255] = 8'd13;
    do_reset();
    pulse_start();
    wait_valid(10, n, ok);
    checks++; if (!ok || n != 2 || opcode !== 8'd5 || has_operand !== 1'b0) begin errors++; $display("FAIL wrap_first: ok %0b n %0d op %0d has %0b want 1 2 5 0", ok, n, opcode, has_operand); end
    accept(1'b1, 8'd255);
    checks++; if (r_addr !== 8'd255) begin errors++; $display("FAIL wrap_fetch_addr: r_addr %0d want 255", r_addr); end
    step();
    checks++; if (r_addr !== 8'd0) begin errors++; $display("FAIL wrap_arg_addr: r_addr %0d want 0", r_addr); end
    wait_valid(10, n, ok);
    checks++; if (!ok || {opcode, operand, pc} !== {8'd13, 8'd5, 8'd255}) begin errors++; $display("FAIL wrap_instr: ok %0b op %0d arg %0d pc %0d want 1 13 5 255", ok, opcode, operand, pc); end
    accept(1'b0, 8'd0);
    wait_valid(10, n, ok);
    checks++; if (!ok || pc !== 8'd1 || opcode !== 8'd4) begin errors++; $display("FAIL wrap_next: ok %0b pc %0d op %0d want 1 1 4", ok, pc, opcode); end
  endtask

  task automatic test_illegal_and_reset();
    int n;
    int seen;
    bit ok;
    clear_mem();
    mem[0] = 8'd99; mem[1] = 8'd4; mem[2] = 8'd0; mem[3] = 8'd7;
    do_reset();
    pulse_start();
    wait_valid(10, n, ok);
    checks++; if (!ok || {illegal_op, has_operand, opcode, operand, pc} !== {1'b1, 1'b0, 8'd99, 8'd0, 8'd0}) begin errors++; $display("FAIL illegal_issue: ok %0b ill %0b has %0b op %0d arg %0d pc %0d want 1 1 0 99 0 0", ok, illegal_op, has_operand, opcode, operand, pc); end
    accept(1'b0, 8'd0);
    wait_valid(10, n, ok);
    checks++; if (!ok || n != 2 || pc !== 8'd1 || illegal_op !== 1'b0) begin errors++; $display("FAIL illegal_next: ok %0b n %0d pc %0d ill %0b want 1 2 1 0", ok, n, pc, illegal_op); end
    accept(1'b0, 8'd0);
    step();
    step();
    checks++; if (r_addr !== 8'd2 || instr_valid !== 1'b0) begin errors++; $display("FAIL latch_arg_addr: r_addr %0d valid %0b want 2 0", r_addr, instr_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if ({instr_valid, pc, r_addr} !== 17'h0) begin errors++; $display("FAIL rst_in_arg: valid %0b pc %0d r_addr %0d want 0 0 0", instr_valid, pc, r_addr); end
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (instr_valid) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL idle_after_rst: valids %0d want 0", seen); end
    pulse_start();
    wait_valid(10, n, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_restart: valid %0b want 1", ok); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL async_drop: valid %0b want 0", instr_valid); end
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_jump();
    test_halt();
    test_wrap();
    test_illegal_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
